// File: rtl/sram_bist_pkg.sv
// Shared types and constants for the SRAM BIST checker.
//   bist_chk_state_t : checker FSM state encoding
//   MAX_READ_LATENCY : deepest SRAM read latency the compare pipeline supports
package sram_bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        DRAIN,
        DONE
    } bist_chk_state_t;

    localparam int MAX_READ_LATENCY = 4;

endpackage

// File: rtl/sram_bist_checker_read_pipe.sv
// bist_read_pipe: delay line carrying {valid, expected, addr} for each issued
// read so the expected value lines up with SRAM read data.
// Ports:
//   clk, rst_n             clock, synchronous active-low reset (clears valids)
//   in_valid/expected/addr entry loaded every cycle at stage 0
//   out_valid/expected/addr last stage (compare point)
//   empty                  no valid entry anywhere in the line
module bist_read_pipe #(
    parameter int DEPTH      = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_expected,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_expected,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  empty
);

    logic [DEPTH-1:0]      valid_q;
    logic [DATA_WIDTH-1:0] exp_q  [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= {valid_q[DEPTH-2:0], in_valid};
        end
    end

    // Payload is only meaningful under its valid bit, so it needs no reset.
    always_ff @(posedge clk) begin
        exp_q[0]  <= in_expected;
        addr_q[0] <= in_addr;
        for (int i = 1; i < DEPTH; i++) begin
            exp_q[i]  <= exp_q[i-1];
            addr_q[i] <= addr_q[i-1];
        end
    end

    assign out_valid    = valid_q[DEPTH-1];
    assign out_expected = exp_q[DEPTH-1];
    assign out_addr     = addr_q[DEPTH-1];
    assign empty        = ~|valid_q;

endmodule

// File: rtl/sram_bist_checker.sv
// SRAM BIST checker: drives a deterministic pattern generator through its
// sequence, forwards its beats to the SRAM ports one cycle later, and compares
// read data against the generator's expected value after READ_LATENCY cycles.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   start            run request (ignored while busy)
//   pg_*             pattern generator handshake and beat fields
//   sram_*           SRAM macro ports (registered)
//   busy, done       run status
//   fail, err_count  sticky mismatch flag, saturating mismatch count
//   first_fail_*     address / read data of the first mismatch of a run
// Build option: SRAM22_BIST_FAIL_LOG_EN keeps the first-failure capture
// registers; without it first_fail_addr/first_fail_data are tied to 0.
//
// State table:
//   IDLE  | waiting for start after reset
//   CLEAR | one-cycle generator reset, results cleared
//   RUN   | issuing generator beats to the SRAM
//   DRAIN | waiting for in-flight reads to be compared
//   DONE  | results held until the next start
module sram_bist_checker
    import sram_bist_pkg::*;
#(
    parameter int ADDR_WIDTH    = 8,
    parameter int DATA_WIDTH    = 32,
    parameter int MASK_WIDTH    = 4,
    parameter int READ_LATENCY  = 1,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     pg_clear,
    output logic                     pg_en,
    input  logic [ADDR_WIDTH-1:0]    pg_addr,
    input  logic [DATA_WIDTH-1:0]    pg_data,
    input  logic [DATA_WIDTH-1:0]    pg_check,
    input  logic [MASK_WIDTH-1:0]    pg_wmask,
    input  logic                     pg_we,
    input  logic                     pg_re,
    input  logic                     pg_done,
    output logic                     sram_ce,
    output logic                     sram_we,
    output logic [ADDR_WIDTH-1:0]    sram_addr,
    output logic [DATA_WIDTH-1:0]    sram_din,
    output logic [MASK_WIDTH-1:0]    sram_wmask,
    input  logic [DATA_WIDTH-1:0]    sram_dout,
    output logic                     busy,
    output logic                     done,
    output logic                     fail,
    output logic [ERR_CNT_WIDTH-1:0] err_count,
    output logic [ADDR_WIDTH-1:0]    first_fail_addr,
    output logic [DATA_WIDTH-1:0]    first_fail_data
);

    // Latencies outside 1..MAX_READ_LATENCY are clamped into range.
    localparam int RL_CLAMPED = (READ_LATENCY < 1) ? 1 :
                                (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY :
                                READ_LATENCY;
    localparam int PIPE_DEPTH = RL_CLAMPED + 1;

    bist_chk_state_t state, state_n;

    logic                  issue;
    logic                  run_start;
    logic                  pipe_out_valid;
    logic [DATA_WIDTH-1:0] pipe_out_expected;
    logic [ADDR_WIDTH-1:0] pipe_out_addr;
    logic                  pipe_empty;
    logic                  cmp_fire;

    // A beat presented together with pg_done is not issued.
    assign issue     = (state == RUN) && !pg_done;
    assign run_start = ((state == IDLE) || (state == DONE)) && start;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        pg_clear = 1'b0;
        pg_en    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_n = CLEAR;
            end
            CLEAR: begin
                pg_clear = 1'b1;
                state_n  = RUN;
            end
            RUN: begin
                busy  = 1'b1;
                pg_en = !pg_done;
                if (pg_done) state_n = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (pipe_empty) state_n = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_n = CLEAR;
            end
            default: state_n = IDLE;
        endcase
    end

    // SRAM ports: one-cycle registered copy of the generator beat.
    // Simultaneous we/re is a write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sram_ce    <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_din   <= '0;
            sram_wmask <= '0;
        end else if (issue) begin
            sram_ce    <= pg_we | pg_re;
            sram_we    <= pg_we;
            sram_addr  <= pg_addr;
            sram_din   <= pg_data;
            sram_wmask <= pg_wmask;
        end else begin
            sram_ce <= 1'b0;
            sram_we <= 1'b0;
        end
    end

    bist_read_pipe #(
        .DEPTH      (PIPE_DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_read_pipe (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (issue && pg_re && !pg_we),
        .in_expected  (pg_check),
        .in_addr      (pg_addr),
        .out_valid    (pipe_out_valid),
        .out_expected (pipe_out_expected),
        .out_addr     (pipe_out_addr),
        .empty        (pipe_empty)
    );

    assign cmp_fire = pipe_out_valid && (sram_dout != pipe_out_expected);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fail      <= 1'b0;
            err_count <= '0;
        end else if (run_start) begin
            fail      <= 1'b0;
            err_count <= '0;
        end else if (cmp_fire) begin
            fail <= 1'b1;
            if (err_count != '1) err_count <= err_count + 1'b1;
        end
    end

`ifdef SRAM22_BIST_FAIL_LOG_EN
    // fail is still low on the first mismatch of a run.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            first_fail_addr <= '0;
            first_fail_data <= '0;
        end else if (run_start) begin
            first_fail_addr <= '0;
            first_fail_data <= '0;
        end else if (cmp_fire && !fail) begin
            first_fail_addr <= pipe_out_addr;
            first_fail_data <= sram_dout;
        end
    end
`else
    logic unused_pipe_addr;
    assign unused_pipe_addr = ^pipe_out_addr;
    assign first_fail_addr  = '0;
    assign first_fail_data  = '0;
`endif

endmodule
